// File: rtl/bram_port_arbiter_pkg.sv
// bram_port_arbiter_pkg: shared defaults and memory latency for the BRAM port arbiter
package bram_port_arbiter_pkg;
   localparam int DATA_WIDTH_DEF   = 32;
   localparam int MEMBLOCKSIZE_DEF = 7424;
   localparam int NREQ_DEF         = 4;
   localparam int MEM_RD_LAT       = 2;
   localparam int RD_STAGES        = MEM_RD_LAT + 1;
endpackage

// File: rtl/bram_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker, search starts just after last_gnt
module rr_picker
   import bram_port_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   localparam int idWidth = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]    req,
   input  logic [idWidth-1:0] last_gnt,
   output logic [NREQ-1:0]    gnt
);
   logic [idWidth-1:0] idx;
   // scan from lowest to highest priority so the highest-priority request is written last
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = idWidth'((int'(last_gnt) + k) % NREQ);
         if (req[idx]) gnt = {{(NREQ-1){1'b0}}, 1'b1} << idx;
      end
   end
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin arbiter with lock, sharing one BRAM port among NREQ requesters
module bram_port_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int dataWidth    = DATA_WIDTH_DEF,
   parameter int memblocksize = MEMBLOCKSIZE_DEF,
   parameter int NREQ         = NREQ_DEF,
   localparam int addressWidth = $clog2(memblocksize / dataWidth),
   localparam int idWidth      = $clog2(NREQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              req,
   input  logic [NREQ-1:0]              req_we,
   input  logic [NREQ-1:0]              req_lock,
   input  logic [NREQ*addressWidth-1:0] req_addr,
   input  logic [NREQ*dataWidth-1:0]    req_wdata,
   output logic [NREQ-1:0]              gnt,
   output logic                         mem_en,
   output logic                         mem_we,
   output logic [addressWidth-1:0]      mem_addr,
   output logic [dataWidth-1:0]         mem_din,
   input  logic [dataWidth-1:0]         mem_dout,
   output logic                         rd_valid,
   output logic [idWidth-1:0]           rd_id,
   output logic [dataWidth-1:0]         rd_data,
   output logic                         busy
);
   logic [idWidth-1:0]   last_gnt;
   logic [idWidth-1:0]   gid;
   logic                 lock;
   logic                 hold;
   logic                 any;
   logic [NREQ-1:0]      pick;
   logic [RD_STAGES-1:0] rd_v;
   logic [idWidth-1:0]   rd_q [RD_STAGES];

   rr_picker #(.NREQ(NREQ)) u_picker (
      .req      (req),
      .last_gnt (last_gnt),
      .gnt      (pick)
   );

   // grant selection: a held lock overrides rotation, and nothing is granted while in reset
   always_comb begin
      hold = lock & req[last_gnt];
      gnt  = !rst ? '0 : hold ? {{(NREQ-1){1'b0}}, 1'b1} << last_gnt : pick;
      any  = |gnt;
      gid  = '0;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gid = idWidth'(i);
   end

   // BRAM port register, arbitration state and read-return tracking shift register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         last_gnt <= idWidth'(NREQ - 1);
         lock     <= 1'b0;
         rd_v     <= '0;
         for (int s = 0; s < RD_STAGES; s++) rd_q[s] <= '0;
      end else begin
         mem_en   <= any;
         mem_we   <= any & req_we[gid];
         mem_addr <= req_addr[int'(gid)*addressWidth +: addressWidth];
         mem_din  <= req_wdata[int'(gid)*dataWidth +: dataWidth];
         lock     <= any & req_lock[gid];
         if (any) last_gnt <= gid;
         rd_v     <= {rd_v[RD_STAGES-2:0], any & ~req_we[gid]};
         rd_q[0]  <= gid;
         for (int s = 1; s < RD_STAGES; s++) rd_q[s] <= rd_q[s-1];
      end
   end

   assign rd_valid = rd_v[RD_STAGES-1];
   assign rd_id    = rd_q[RD_STAGES-1];
   assign rd_data  = rd_valid ? mem_dout : '0;
   assign busy     = |rd_v;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed checks of grant order, lock, read return and reset behaviour
module tb_bram_port_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [3:0]  req_we = '0;
   logic [3:0]  req_lock = '0;
   logic [31:0] req_addr = '0;
   logic [127:0] req_wdata = '0;
   logic [3:0]  gnt;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        rd_valid;
   logic [1:0]  rd_id;
   logic [31:0] rd_data;
   logic        busy;
   bit   [31:0] mem [256];
   logic [31:0] q1;
   int          checks = 0;
   int          failures = 0;

   bram_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_we    (req_we),
      .req_lock  (req_lock),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .rd_valid  (rd_valid),
      .rd_id     (rd_id),
      .rd_data   (rd_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // BRAM model: two-cycle read latency, write on enable; address 5 preloaded while in reset
   always @(posedge clk) begin
      if (!rst) mem[5] <= 32'hDEADBEEF;
      else if (mem_en && mem_we) mem[mem_addr] <= mem_din;
      q1       <= mem[mem_addr];
      mem_dout <= q1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      req = '0;
      req_we = '0;
      req_lock = '0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      req = 4'b1111;
      tick();
      tick();
      check("rst_gnt", gnt, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_din", mem_din, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_busy", busy, 0);

      // single read of address 5 in the first cycle out of reset
      reset_dut();
      req = 4'b0001;
      req_addr[7:0] = 8'd5;
      #1 check("t1_gnt", gnt, 4'b0001);
      tick();
      req = '0;
      #1 check("t1_mem_en", mem_en, 1);
      check("t1_mem_addr", mem_addr, 5);
      check("t1_mem_we", mem_we, 0);
      check("t1_busy", busy, 1);
      check("t1_gnt_idle", gnt, 0);
      tick();
      #1 check("t1_mem_en_idle", mem_en, 0);
      check("t1_rd_valid_early", rd_valid, 0);
      tick();
      #1 check("t1_rd_valid", rd_valid, 1);
      check("t1_rd_id", rd_id, 0);
      check("t1_rd_data", rd_data, 32'hDEADBEEF);
      tick();
      #1 check("t1_rd_valid_end", rd_valid, 0);
      check("t1_busy_end", busy, 0);

      // full rotation with all requesters reading back to back
      reset_dut();
      for (int k = 0; k < 8; k++) begin
         req = 4'b1111;
         #1 check($sformatf("t2_gnt%0d", k), gnt, 4'b0001 << (k % 4));
         if (k >= 3) begin
            check($sformatf("t2_rd_valid%0d", k), rd_valid, 1);
            check($sformatf("t2_rd_id%0d", k), rd_id, (k - 3) % 4);
         end
         tick();
      end
      req = '0;

      // lock on requester 0 holds the grant one cycle past the last lock request
      reset_dut();
      for (int k = 0; k < 5; k++) begin
         req = 4'b0011;
         req_lock = (k < 3) ? 4'b0001 : 4'b0000;
         #1 check($sformatf("t3_gnt%0d", k), gnt, (k < 4) ? 4'b0001 : 4'b0010);
         tick();
      end
      req = '0;
      req_lock = '0;

      // write by requester 2 then read of the same address by requester 1
      reset_dut();
      req = 4'b0100;
      req_we = 4'b0100;
      req_addr[23:16] = 8'd9;
      req_wdata[95:64] = 32'h12345678;
      #1 check("t4_gnt_w", gnt, 4'b0100);
      tick();
      req = 4'b0010;
      req_we = '0;
      req_addr[15:8] = 8'd9;
      #1 check("t4_gnt_r", gnt, 4'b0010);
      check("t4_mem_we", mem_we, 1);
      check("t4_mem_addr", mem_addr, 9);
      check("t4_mem_din", mem_din, 32'h12345678);
      tick();
      req = '0;
      #1 check("t4_mem_we_rd", mem_we, 0);
      tick();
      #1 check("t4_no_wr_valid", rd_valid, 0);
      tick();
      #1 check("t4_rd_valid", rd_valid, 1);
      check("t4_rd_id", rd_id, 1);
      check("t4_rd_data", rd_data, 32'h12345678);

      // reset while three reads are in flight discards them
      reset_dut();
      for (int k = 0; k < 3; k++) begin
         req = 4'b0001 << k;
         #1 check($sformatf("t5_gnt%0d", k), gnt, 4'b0001 << k);
         tick();
      end
      req = '0;
      rst = 1'b0;
      #1 check("t5_mem_en", mem_en, 0);
      check("t5_mem_we", mem_we, 0);
      check("t5_mem_addr", mem_addr, 0);
      check("t5_rd_valid", rd_valid, 0);
      check("t5_rd_id", rd_id, 0);
      check("t5_busy", busy, 0);
      check("t5_gnt", gnt, 0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1 check($sformatf("t5_post_valid%0d", k), rd_valid, 0);
         check($sformatf("t5_post_busy%0d", k), busy, 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  dataWidth, 32, word width in bits.
  memblocksize, 7424, BRAM size in bits.
  NREQ, 4, number of requesters (2..16).
REQ-002 Derived constants SHALL be:
  addressWidth = $clog2(memblocksize/dataWidth), which is 8 at defaults.
  idWidth = $clog2(NREQ).
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all logic on its rising edge.
  rst  in  1  asynchronous, active-low reset.
  req  in  NREQ  per-requester access request; held until granted.
  req_we  in  NREQ  per-requester access type: 1 = write, 0 = read.
  req_lock  in  NREQ  keep the grant on the same requester next cycle.
  req_addr  in  NREQ*addressWidth  flattened addresses; requester i at slice i.
  req_wdata  in  NREQ*dataWidth  flattened write data.
  gnt  out  NREQ  one-hot grant; zero or one bit set.
  mem_en  out  1  BRAM port enable.
  mem_we  out  1  BRAM port write enable.
  mem_addr  out  addressWidth  BRAM port address.
  mem_din  out  dataWidth  BRAM port write data.
  mem_dout  in  dataWidth  BRAM port read data; valid 2 cycles after the address.
  rd_valid  out  1  read data return strobe.
  rd_id  out  idWidth  requester index of the returned read.
  rd_data  out  dataWidth  returned read data.
  busy  out  1  at least one read is in flight.

Function
REQ-004 gnt SHALL be combinational from req, the round-robin pointer and the lock state.
REQ-005 A transfer SHALL complete in cycle T when req[i] and gnt[i] are both 1 in T.
REQ-006 Round-robin search SHALL start at index (last_gnt+1) mod NREQ and take the first set req bit.
REQ-007 last_gnt SHALL update only in cycles with a grant.
REQ-008 If req[last_gnt] and req_lock[last_gnt] were both 1 in T-1 and req[last_gnt] is 1 in T, gnt SHALL stay on last_gnt, with no rotation.
REQ-009 If req is all zero, gnt SHALL be 0 and mem_en SHALL be 0 in T+1.
REQ-010 For a grant in T, mem_en, mem_we, mem_addr and mem_din SHALL be registered copies of the granted requester's values in T+1.
REQ-011 For a granted read in T:
  rd_valid=1 in T+3.
  rd_data = mem_dout in T+3, passed combinationally.
  rd_id = granted index.
  Total read latency is fixed at 3 cycles.
REQ-012 Granted writes SHALL produce no rd_valid pulse.
REQ-013 Read tracking SHALL use a 3-stage valid/id shift register.
REQ-014 Back-to-back grants SHALL be sustained at one per cycle, with no bubble between them.
REQ-015 Up to 3 reads SHALL be in flight at once.
REQ-016 busy SHALL equal the OR of the shift-register valid stages.
REQ-017 The block SHALL do no hazard checking; a read after a write to the same address returns the new data because of port ordering.
REQ-018 When mem_en=0, mem_we SHALL be 0; mem_addr and mem_din are don't-care.

Reset
REQ-019 On rst=0, asynchronously:
  mem_en, mem_we, mem_addr, mem_din SHALL be 0.
  rd_valid, rd_id, busy SHALL be 0.
  Lock state SHALL be cleared.
  last_gnt SHALL be NREQ-1, so requester 0 has first priority.
REQ-020 gnt SHALL be forced to 0 while rst=0.
REQ-021 Reset mid-operation SHALL discard in-flight reads; no rd_valid after release for pre-reset grants.
REQ-022 The first grant SHALL be possible in the first cycle with rst=1.

Structure
REQ-023 A shared package SHALL hold the default dataWidth, memblocksize and NREQ values and the latency constant MEM_RD_LAT=2.
REQ-024 The combinational round-robin priority picker SHALL be one sub-module, rr_picker (inputs req, last_gnt; output one-hot gnt).
REQ-025 The arbiter SHALL connect to one port of the existing dual-port BRAM wrapper; the wrapper enable is driven by mem_en.

Verification
REQ-026 Reset, then req=4'b0001 read at addr 5, with the memory holding 0xDEADBEEF at address 5. Required response:
  gnt=0001 in the same cycle.
  mem_en=1, mem_addr=5 the next cycle.
  rd_valid=1, rd_id=0, rd_data=0xDEADBEEF 3 cycles after the grant.
REQ-027 req=4'b1111 held for 8 cycles, no lock. Required response: gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000, one grant per cycle.
REQ-028 req=4'b0011 with req_lock[0]=1 for 3 cycles. Required response: gnt=0001 for 4 consecutive cycles, then 0010.
REQ-029 Requester 2 writes 0x12345678 to addr 9, then requester 1 reads addr 9 in the next cycle. Required response:
  No rd_valid for the write.
  rd_id=1, rd_data=0x12345678 in read grant+3.
REQ-030 3 back-to-back reads from requesters 0,1,2, with rst pulsed low in read-grant+1. Required response:
  All outputs go 0 immediately.
  busy=0.
  No rd_valid for 5 cycles after release with req=0.
